// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that feeds a UART transmitter through a one-byte-in-flight
// handshake (IDLE -> LOAD -> WAIT_BUSY -> WAIT_DONE).
// Optional feature: define UART_TX_FIFO_OVERFLOW_EN to build the sticky overflow flag;
// without it overflow is tied to 0 and no overflow register exists.
module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     uart_tx_en,
  output logic [7:0]               uart_tx_data,
  input  logic                     uart_tx_busy,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  state_t        state_r;
  state_t        state_next_s;
  logic          pending_r;
  logic          push_s;
  logic          pop_s;
  logic          tx_en_r;
  logic [7:0]    tx_data_r;

  // Flags come straight from the registered count, so a write on a full FIFO is
  // dropped even if the FSM pops in the same cycle.
  assign full         = (count_r == FULL_COUNT);
  assign empty        = (count_r == '0);
  assign count        = count_r;
  assign uart_tx_en   = tx_en_r;
  assign uart_tx_data = tx_data_r;

  // Accept a write only when there is room and no flush is discarding the queue.
  always_comb begin
    push_s = 1'b0;
    if (wr_en && !full && !flush) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
  end

  // Next-state and pop decision. pending_r delays the first pop by one cycle so a
  // byte written into an empty FIFO starts the UART two cycles after it is sampled.
  always_comb begin
    state_next_s = state_r;
    pop_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty && pending_r && !uart_tx_busy && !flush) begin
          state_next_s = LOAD;
          pop_s        = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      LOAD: begin
        state_next_s = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (uart_tx_busy) begin
          state_next_s = WAIT_DONE;
        end else begin
          state_next_s = WAIT_BUSY;
        end
      end
      WAIT_DONE: begin
        if (!uart_tx_busy) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = WAIT_DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // FSM state register; flush deliberately leaves the transfer in progress alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Remembers that the queue was non-empty on the previous cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= 1'b0;
    end else if (flush) begin
      pending_r <= 1'b0;
    end else begin
      pending_r <= !empty;
    end
  end

  // Storage array; contents need no reset because pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem[wr_ptr_r] <= wr_data;
    end
  end

  // Circular pointers and occupancy count; flush wins over any same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Output byte register: loaded on the pop and held for the whole transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_r <= 8'h00;
    end else if (pop_s) begin
      tx_data_r <= mem[rd_ptr_r];
    end else begin
      tx_data_r <= tx_data_r;
    end
  end

  // Start pulse is high exactly while the FSM sits in LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_en_r <= 1'b0;
    end else begin
      tx_en_r <= (state_next_s == LOAD);
    end
  end

`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic overflow_r;

  // Sticky dropped-write flag; only reset or flush clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
    end else if (flush) begin
      overflow_r <= 1'b0;
    end else if (wr_en && full) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  assign overflow = overflow_r;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: accepted bytes are queued when written and
// compared against uart_tx_data on every uart_tx_en pulse. A small stub models
// the UART busy flag (rises stub_delay cycles after the pulse, lasts stub_len).
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
`ifdef UART_TX_FIFO_OVERFLOW_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       wr_en   = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       flush   = 1'b0;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       uart_tx_en;
  logic [7:0] uart_tx_data;
  logic       uart_tx_busy;
  logic       overflow;

  int         n_checks   = 0;
  int         n_fail     = 0;
  int         n_pulses   = 0;
  logic [7:0] exp_q[$];

  logic       busy_hold  = 1'b0;
  int         stub_cnt   = 0;
  int         stub_delay = 2;
  int         stub_len   = 4;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .flush        (flush),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .uart_tx_en   (uart_tx_en),
    .uart_tx_data (uart_tx_data),
    .uart_tx_busy (uart_tx_busy),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  assign uart_tx_busy = busy_hold || (stub_cnt != 0 && stub_cnt >= stub_delay);

  // UART busy stub
  always @(posedge clk) begin
    if (stub_cnt == 0) begin
      if (uart_tx_en) stub_cnt <= 1;
    end else if (stub_cnt >= stub_delay + stub_len) begin
      stub_cnt <= 0;
    end else begin
      stub_cnt <= stub_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard consumer: each start pulse must carry the oldest queued byte
  always @(negedge clk) begin
    if (rst_n && uart_tx_en) begin
      n_pulses++;
      if (exp_q.size() == 0) check("spurious_tx_en", 32'd1, 32'd0);
      else check("tx_data", {24'h0, uart_tx_data}, {24'h0, exp_q.pop_front()});
    end
  end

  task automatic push(input logic [7:0] d, input bit accept);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = d;
    if (accept) exp_q.push_back(d);
  endtask

  task automatic stop_push();
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int i;
    for (i = 0; i < 400; i++) begin
      if (exp_q.size() == 0 && stub_cnt == 0 && !uart_tx_busy && empty) break;
      @(negedge clk);
    end
    check(tag, (i >= 400) ? 32'd1 : 32'd0, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int i;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_count", {27'd0, count}, 32'd0);
    check("rst_tx_en", {31'd0, uart_tx_en}, 32'd0);
    check("rst_tx_data", {24'd0, uart_tx_data}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;

    // Single byte: pulse between edges k+2 and k+3
    p0 = n_pulses;
    push(8'hA5, 1'b1);
    stop_push();
    check("lat_count_k", {27'd0, count}, 32'd1);
    check("lat_en_k", {31'd0, uart_tx_en}, 32'd0);
    @(negedge clk);
    check("lat_en_k1", {31'd0, uart_tx_en}, 32'd0);
    @(negedge clk);
    check("lat_en_k2", {31'd0, uart_tx_en}, 32'd1);
    check("lat_count_k2", {27'd0, count}, 32'd0);
    wait_drain("single_drain");
    check("single_pulses", n_pulses - p0, 32'd1);

    // Back-to-back bytes
    p0 = n_pulses;
    push(8'hA5, 1'b1);
    push(8'h3C, 1'b1);
    push(8'hFF, 1'b1);
    stop_push();
    wait_drain("b2b_drain");
    check("b2b_pulses", n_pulses - p0, 32'd3);

    // Full / overflow with the UART held busy
    @(negedge clk);
    busy_hold = 1'b1;
    p0 = n_pulses;
    for (i = 0; i <= DEPTH; i++) push(8'(i), i < DEPTH);
    stop_push();
    check("full_flag", {31'd0, full}, 32'd1);
    check("full_count", {27'd0, count}, 32'd16);
    check("full_empty", {31'd0, empty}, 32'd0);
    check("full_overflow", {31'd0, overflow}, {31'd0, EXP_OVF});
    busy_hold = 1'b0;
    wait_drain("full_drain");
    check("full_pulses", n_pulses - p0, 32'd16);
    check("ovf_sticky", {31'd0, overflow}, {31'd0, EXP_OVF});
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("ovf_flush_clear", {31'd0, overflow}, 32'd0);

    // Flush while 0x11 is in flight
    stub_len = 10;
    p0 = n_pulses;
    push(8'h11, 1'b1);
    push(8'h22, 1'b1);
    push(8'h33, 1'b1);
    stop_push();
    for (i = 0; i < 50 && !uart_tx_busy; i++) @(negedge clk);
    check("flush_busy_seen", {31'd0, uart_tx_busy}, 32'd1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_q_left", exp_q.size(), 32'd2);
    exp_q.delete();
    check("flush_count", {27'd0, count}, 32'd0);
    check("flush_empty", {31'd0, empty}, 32'd1);
    check("flush_overflow", {31'd0, overflow}, 32'd0);
    check("flush_data_held", {24'd0, uart_tx_data}, 32'h11);
    wait_drain("flush_drain");
    check("flush_pulses", n_pulses - p0, 32'd1);
    stub_len = 4;

    // Reset during WAIT_BUSY with four bytes still queued
    stub_delay = 6;
    p0 = n_pulses;
    for (i = 0; i < 5; i++) push(8'h61 + 8'(i), 1'b1);
    stop_push();
    for (i = 0; i < 50 && n_pulses == p0; i++) @(negedge clk);
    check("rst_mid_pulse_seen", n_pulses - p0, 32'd1);
    @(negedge clk);
    check("rst_mid_count_before", {27'd0, count}, 32'd4);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_tx_en", {31'd0, uart_tx_en}, 32'd0);
    check("rst_mid_tx_data", {24'd0, uart_tx_data}, 32'd0);
    check("rst_mid_empty", {31'd0, empty}, 32'd1);
    check("rst_mid_count", {27'd0, count}, 32'd0);
    exp_q.delete();
    for (i = 0; i < 50 && stub_cnt != 0; i++) @(negedge clk);
    stub_delay = 2;
    p0 = n_pulses;
    @(negedge clk);
    rst_n   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'h5A;
    exp_q.push_back(8'h5A);
    stop_push();
    check("post_rst_accept", {27'd0, count}, 32'd1);
    wait_drain("post_rst_drain");
    check("post_rst_pulses", n_pulses - p0, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
